// File: rtl/board_state_controller_if.sv
// Click/new-game stimulus from the mouse side and board status toward the figure generators.
interface board_state_controller_if #(
    parameter int BITS_SCREEN_WIDTH  = 8,
    parameter int BITS_SCREEN_HEIGHT = 9
);
    logic                          click;
    logic [BITS_SCREEN_WIDTH-1:0]  click_x;
    logic [BITS_SCREEN_HEIGHT-1:0] click_y;
    logic                          new_game;
    logic [8:0]                    x_status;
    logic [8:0]                    o_status;
    logic                          turn;
    logic                          move_accept;
    logic                          move_reject;
    logic                          game_over;
    logic [1:0]                    winner;

    modport master (
        output click, click_x, click_y, new_game,
        input  x_status, o_status, turn, move_accept, move_reject, game_over, winner
    );

    modport slave (
        input  click, click_x, click_y, new_game,
        output x_status, o_status, turn, move_accept, move_reject, game_over, winner
    );
endinterface

// File: rtl/board_state_controller.sv
// Tic-tac-toe game-state owner: maps LCD clicks to cells, keeps X/O bitmaps, turn and result.
//
// state  | meaning
// IDLE   | waiting for a click; the only state that samples click
// DECODE | map registered coordinates to a cell, accept or reject the move
// CHECK  | test the mover's bitmap for a line or a full board
// OVER   | game finished; clicks ignored until new_game or reset
module board_state_controller #(
    parameter int BITS_SCREEN_WIDTH  = 8,
    parameter int BITS_SCREEN_HEIGHT = 9
) (
    input  logic                     clock,
    input  logic                     resetn,
    board_state_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        CHECK  = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [BITS_SCREEN_WIDTH-1:0]  cx_r;
    logic [BITS_SCREEN_HEIGHT-1:0] cy_r;
    logic [8:0]                    x_r, x_nxt;
    logic [8:0]                    o_r, o_nxt;
    logic                          turn_r, turn_nxt;
    logic                          acc_r, acc_nxt;
    logic                          rej_r, rej_nxt;
    logic                          go_r, go_nxt;
    logic [1:0]                    win_r, win_nxt;

    logic       col_ok, row_ok;
    logic [1:0] col_idx, row_idx;
    logic [3:0] cell_idx;
    logic [8:0] cell_mask;
    logic       occupied;
    logic       cell_ok;
    logic [8:0] mover_map;
    logic       line_done;
    logic       board_full;
    logic       take_click;

    function automatic logic has_line(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // Gridlines sit between the cell ranges, so they fall through to invalid.
    always_comb begin
        col_ok  = 1'b1;
        col_idx = 2'd0;
        if (cx_r >= 1 && cx_r <= 77) begin
            col_idx = 2'd0;
        end else if (cx_r >= 81 && cx_r <= 157) begin
            col_idx = 2'd1;
        end else if (cx_r >= 161 && cx_r <= 237) begin
            col_idx = 2'd2;
        end else begin
            col_ok = 1'b0;
        end
    end

    // Row 0 is at the bottom of the LCD (largest y).
    always_comb begin
        row_ok  = 1'b1;
        row_idx = 2'd0;
        if (cy_r >= 202 && cy_r <= 278) begin
            row_idx = 2'd0;
        end else if (cy_r >= 122 && cy_r <= 198) begin
            row_idx = 2'd1;
        end else if (cy_r >= 42 && cy_r <= 118) begin
            row_idx = 2'd2;
        end else begin
            row_ok = 1'b0;
        end
    end

    assign cell_idx   = ({2'b00, col_idx} * 4'd3) + {2'b00, row_idx};
    assign cell_mask  = 9'd1 << cell_idx;
    assign occupied   = |(cell_mask & (x_r | o_r));
    assign cell_ok    = col_ok & row_ok & ~occupied;
    assign mover_map  = turn_r ? o_r : x_r;
    assign line_done  = has_line(mover_map);
    assign board_full = &(x_r | o_r);
    assign take_click = (state == IDLE) & bus.click & ~bus.new_game;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= IDLE;
            cx_r   <= '0;
            cy_r   <= '0;
            x_r    <= '0;
            o_r    <= '0;
            turn_r <= 1'b0;
            acc_r  <= 1'b0;
            rej_r  <= 1'b0;
            go_r   <= 1'b0;
            win_r  <= 2'b00;
        end else begin
            state  <= state_nxt;
            if (take_click) begin
                cx_r <= bus.click_x;
                cy_r <= bus.click_y;
            end
            x_r    <= x_nxt;
            o_r    <= o_nxt;
            turn_r <= turn_nxt;
            acc_r  <= acc_nxt;
            rej_r  <= rej_nxt;
            go_r   <= go_nxt;
            win_r  <= win_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.new_game) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.click) state_nxt = DECODE;
                DECODE:  state_nxt = cell_ok ? CHECK : IDLE;
                CHECK:   state_nxt = (line_done || board_full) ? OVER : IDLE;
                OVER:    state_nxt = OVER;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The mover's turn is kept through CHECK so the win is credited to them.
    always_comb begin
        x_nxt    = x_r;
        o_nxt    = o_r;
        turn_nxt = turn_r;
        acc_nxt  = 1'b0;
        rej_nxt  = 1'b0;
        go_nxt   = go_r;
        win_nxt  = win_r;
        if (bus.new_game) begin
            x_nxt    = '0;
            o_nxt    = '0;
            turn_nxt = 1'b0;
            go_nxt   = 1'b0;
            win_nxt  = 2'b00;
        end else begin
            case (state)
                DECODE: begin
                    if (cell_ok) begin
                        if (turn_r) o_nxt = o_r | cell_mask;
                        else        x_nxt = x_r | cell_mask;
                        acc_nxt = 1'b1;
                    end else begin
                        rej_nxt = 1'b1;
                    end
                end
                CHECK: begin
                    if (line_done) begin
                        go_nxt  = 1'b1;
                        win_nxt = turn_r ? 2'b10 : 2'b01;
                    end else if (board_full) begin
                        go_nxt  = 1'b1;
                        win_nxt = 2'b11;
                    end else begin
                        turn_nxt = ~turn_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.x_status    = x_r;
    assign bus.o_status    = o_r;
    assign bus.turn        = turn_r;
    assign bus.move_accept = acc_r;
    assign bus.move_reject = rej_r;
    assign bus.game_over   = go_r;
    assign bus.winner      = win_r;

endmodule

// File: tb/tb_board_state_controller.sv
// Directed bench for board_state_controller with a reference game model feeding a scoreboard.
module tb_board_state_controller;

    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    board_state_controller_if #(.BITS_SCREEN_WIDTH(8), .BITS_SCREEN_HEIGHT(9)) bus ();

    board_state_controller #(.BITS_SCREEN_WIDTH(8), .BITS_SCREEN_HEIGHT(9)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        string      tag;
        logic       acc;
        logic       rej;
        logic [8:0] xs;
        logic [8:0] os;
        logic       trn;
        logic       go;
        logic [1:0] win;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [8:0] mx, mo;
    logic       mturn, mgo;
    logic [1:0] mwin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int ref_cell(input int x, input int y);
        int c = -1;
        int r = -1;
        for (int k = 0; k < 3; k++) begin
            if (x >= 1 + 80 * k && x <= 77 + 80 * k) c = k;
            if (y >= 202 - 80 * k && y <= 278 - 80 * k) r = k;
        end
        if (c < 0 || r < 0) return -1;
        return 3 * c + r;
    endfunction

    function automatic logic ref_line(input logic [8:0] b);
        return ((b & 9'h007) == 9'h007) || ((b & 9'h038) == 9'h038) ||
               ((b & 9'h1C0) == 9'h1C0) || ((b & 9'h049) == 9'h049) ||
               ((b & 9'h092) == 9'h092) || ((b & 9'h124) == 9'h124) ||
               ((b & 9'h111) == 9'h111) || ((b & 9'h054) == 9'h054);
    endfunction

    task automatic model_clear();
        mx = '0; mo = '0; mturn = 1'b0; mgo = 1'b0; mwin = 2'b00;
    endtask

    task automatic model_click(input int x, input int y, input string tag);
        exp_t       e;
        int         c;
        logic [3:0] ci;
        e.tag = tag;
        e.acc = 1'b0;
        e.rej = 1'b0;
        if (!mgo) begin
            c  = ref_cell(x, y);
            ci = 4'(c);
            if (c < 0) begin
                e.rej = 1'b1;
            end else if (mx[ci] || mo[ci]) begin
                e.rej = 1'b1;
            end else begin
                e.acc = 1'b1;
                if (mturn) mo[ci] = 1'b1;
                else       mx[ci] = 1'b1;
                if (ref_line(mturn ? mo : mx)) begin
                    mgo  = 1'b1;
                    mwin = mturn ? 2'b10 : 2'b01;
                end else if ((mx | mo) == 9'h1FF) begin
                    mgo  = 1'b1;
                    mwin = 2'b11;
                end else begin
                    mturn = ~mturn;
                end
            end
        end
        e.xs  = mx;
        e.os  = mo;
        e.trn = mturn;
        e.go  = mgo;
        e.win = mwin;
        sb.push_back(e);
    endtask

    // Click sampled at edge T; pulse and bitmap expected after T+1, turn/result after T+2.
    task automatic do_click(input int x, input int y, input string tag);
        exp_t e;
        int   waited;
        model_click(x, y, tag);
        @(negedge clock);
        bus.click   = 1'b1;
        bus.click_x = 8'(x);
        bus.click_y = 9'(y);
        @(negedge clock);
        bus.click = 1'b0;
        waited = 0;
        while (!(bus.move_accept || bus.move_reject) && waited < 6) begin
            @(negedge clock);
            waited++;
        end
        e = sb.pop_front();
        check({e.tag, "/accept"}, 32'(bus.move_accept), 32'(e.acc));
        check({e.tag, "/reject"}, 32'(bus.move_reject), 32'(e.rej));
        check({e.tag, "/x_status"}, 32'(bus.x_status), 32'(e.xs));
        check({e.tag, "/o_status"}, 32'(bus.o_status), 32'(e.os));
        if (e.acc || e.rej) check({e.tag, "/latency"}, 32'(waited), 32'd1);
        @(negedge clock);
        check({e.tag, "/pulse_end"}, 32'({bus.move_accept, bus.move_reject}), 32'd0);
        check({e.tag, "/turn"}, 32'(bus.turn), 32'(e.trn));
        check({e.tag, "/game_over"}, 32'(bus.game_over), 32'(e.go));
        check({e.tag, "/winner"}, 32'(bus.winner), 32'(e.win));
    endtask

    task automatic click_cell(input int c, input string tag);
        do_click(40 + 80 * (c / 3), 240 - 80 * (c % 3), tag);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "/x_status"}, 32'(bus.x_status), 32'h000);
        check({tag, "/o_status"}, 32'(bus.o_status), 32'h000);
        check({tag, "/turn"}, 32'(bus.turn), 32'd0);
        check({tag, "/pulses"}, 32'({bus.move_accept, bus.move_reject}), 32'd0);
        check({tag, "/game_over"}, 32'(bus.game_over), 32'd0);
        check({tag, "/winner"}, 32'(bus.winner), 32'd0);
    endtask

    task automatic pulse_new_game(input string tag);
        @(negedge clock);
        bus.new_game = 1'b1;
        @(negedge clock);
        bus.new_game = 1'b0;
        model_clear();
        check_cleared(tag);
    endtask

    initial begin
        resetn       = 1'b0;
        bus.click    = 1'b0;
        bus.click_x  = '0;
        bus.click_y  = '0;
        bus.new_game = 1'b0;
        model_clear();
        repeat (3) @(negedge clock);
        check_cleared("reset");
        resetn = 1'b1;

        // Test 1/2: first X move, then O clicks the same cell
        do_click(40, 240, "t1_x_cell0");
        check("t1_x_status_const", 32'(bus.x_status), 32'h001);
        check("t1_turn_const", 32'(bus.turn), 32'd1);
        do_click(40, 240, "t2_occupied");
        check("t2_o_status_const", 32'(bus.o_status), 32'h000);

        // Test 3: gridlines and margins
        do_click(79, 240, "t3_vgrid");
        do_click(40, 20, "t3_margin");
        do_click(40, 200, "t3_hgrid");
        do_click(238, 240, "t3_right_margin");
        do_click(0, 240, "t3_x_zero");

        // Test 4: X wins on column 0 (cells 0,1,2)
        click_cell(3, "t4_o3");
        click_cell(1, "t4_x1");
        click_cell(4, "t4_o4");
        click_cell(2, "t4_x2");
        check("t4_x_status_const", 32'(bus.x_status), 32'h007);
        check("t4_o_status_const", 32'(bus.o_status), 32'h018);
        check("t4_winner_const", 32'(bus.winner), 32'd1);
        do_click(200, 80, "t4_over_click");

        // Test 5: full-board draw, some moves on range edges
        pulse_new_game("ng1");
        do_click(1, 202, "t5_x0");
        click_cell(1, "t5_o1");
        do_click(77, 118, "t5_x2");
        click_cell(4, "t5_o4");
        do_click(81, 278, "t5_x3");
        do_click(157, 42, "t5_o5");
        click_cell(7, "t5_x7");
        do_click(161, 278, "t5_o6");
        do_click(237, 42, "t5_x8");
        check("t5_x_status_const", 32'(bus.x_status), 32'h18D);
        check("t5_o_status_const", 32'(bus.o_status), 32'h072);
        check("t5_winner_const", 32'(bus.winner), 32'd3);
        check("t5_game_over_const", 32'(bus.game_over), 32'd1);

        // Test 6: new_game beats a simultaneous click
        pulse_new_game("ng2");
        click_cell(0, "t6_x0");
        click_cell(4, "t6_o4");
        @(negedge clock);
        bus.click    = 1'b1;
        bus.click_x  = 8'd200;
        bus.click_y  = 9'd80;
        bus.new_game = 1'b1;
        @(negedge clock);
        bus.click    = 1'b0;
        bus.new_game = 1'b0;
        model_clear();
        check_cleared("t6_ng_click");
        repeat (3) begin
            @(negedge clock);
            check("t6_dropped_pulses", 32'({bus.move_accept, bus.move_reject}), 32'd0);
            check("t6_dropped_x", 32'(bus.x_status), 32'h000);
        end

        // Reset while in DECODE aborts the move
        @(negedge clock);
        bus.click   = 1'b1;
        bus.click_x = 8'd40;
        bus.click_y = 9'd240;
        @(negedge clock);
        bus.click = 1'b0;
        resetn    = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check_cleared("t6_reset_decode");
        @(negedge clock);
        check("t6_reset_no_late_accept", 32'({bus.move_accept, bus.move_reject}), 32'd0);
        click_cell(2, "t6_after_reset");
        check("t6_after_reset_x_const", 32'(bus.x_status), 32'h004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
